// File: rtl/y86_pkg.sv
// Shared Y-86 encodings for the write-back stage: instruction codes, status
// codes, special register ids and the status FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic {
    ST_RUN,
    ST_STOP
  } wb_state_e;

  // Fetch faults outrank data faults, which outrank a clean halt.
  function automatic logic [2:0] status_of(input logic       imem_err,
                                           input logic       ins_err,
                                           input logic       dmem_err,
                                           input logic [3:0] icode);
    if (imem_err)              return S_ADR;
    else if (ins_err)          return S_INS;
    else if (dmem_err)         return S_ADR;
    else if (icode == I_HALT)  return S_HLT;
    else                       return S_AOK;
  endfunction

endpackage

// File: rtl/regfile.sv
// 15 x 64-bit Y-86 register file: two combinational read ports (id F reads 0)
// and two write ports committed at the clock edge, port M winning on a clash.
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i,
  input  logic [3:0]  src_a_i,
  input  logic [3:0]  src_b_i,
  output logic [63:0] val_a_o,
  output logic [63:0] val_b_o
);

  logic [63:0] regs_q [15];

  // NOTE: this array must clear asynchronously, so it is built from flops with
  // a reset rather than a RAM macro; a memory without reset would not need this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      for (int i = 0; i < 15; i++) begin
        if (we_m_i && dst_m_i == 4'(i))      regs_q[i] <= val_m_i;
        else if (we_e_i && dst_e_i == 4'(i)) regs_q[i] <= val_e_i;
      end
    end
  end

  assign val_a_o = (src_a_i == RNONE) ? 64'd0 : regs_q[src_a_i];
  assign val_b_o = (src_b_i == RNONE) ? 64'd0 : regs_q[src_b_i];

endmodule

// File: rtl/writeback.sv
// Y-86 write-back stage: destination selection, register commit, sticky
// processor status FSM and retired-instruction counter.
module writeback
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        instr_err,
  input  logic        dmem_error,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [2:0]  stat,
  output logic        halted,
  output logic        wb_done,
  output logic [31:0] retired
);

  wb_state_e   state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] retired_q, retired_d;
  logic        wb_done_q, wb_done_d;

  logic        accept;
  logic        commit;
  logic [2:0]  new_stat;
  logic [3:0]  dst_e, dst_m;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      I_RRMOVQ:                         if (ifun == 4'h0 || cnd) dst_e = rb;
      I_IRMOVQ, I_OPQ:                  dst_e = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:   dst_e = RRSP;
      default:                          dst_e = RNONE;
    endcase
    if (icode == I_MRMOVQ || icode == I_POPQ) dst_m = ra;
  end

  assign new_stat = status_of(imem_error, instr_err, dmem_error, icode);
  assign accept   = wb_valid && (state_q == ST_RUN);
  // Faulting and halting instructions retire but never touch the registers.
  assign commit   = accept && (new_stat == S_AOK);

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    wb_done_d = 1'b0;
    if (accept) begin
      stat_d    = new_stat;
      retired_d = retired_q + 32'd1;
      wb_done_d = 1'b1;
      if (new_stat != S_AOK) state_d = ST_STOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stat_q    <= S_AOK;
      retired_q <= '0;
      wb_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      wb_done_q <= wb_done_d;
    end
  end

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_e_i  (commit),
    .dst_e_i (dst_e),
    .val_e_i (valE),
    .we_m_i  (commit),
    .dst_m_i (dst_m),
    .val_m_i (valM),
    .src_a_i (srcA),
    .src_b_i (srcB),
    .val_a_o (valA),
    .val_b_o (valB)
  );

  assign stat    = stat_q;
  assign halted  = (state_q == ST_STOP);
  assign wb_done = wb_done_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for the Y-86 write-back stage: directed scenarios followed
// by randomized instruction streams against an instruction-level model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  icode, ifun, ra, rb;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        imem_error, instr_err, dmem_error;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA, valB;
  logic [2:0]  stat;
  logic        halted, wb_done;
  logic [31:0] retired;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid),
    .icode(icode), .ifun(ifun), .ra(ra), .rb(rb), .cnd(cnd),
    .valE(valE), .valM(valM),
    .imem_error(imem_error), .instr_err(instr_err), .dmem_error(dmem_error),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .stat(stat), .halted(halted), .wb_done(wb_done), .retired(retired)
  );

  typedef struct packed {
    logic [2:0]        stat;
    logic              halted;
    logic [31:0]       retired;
    logic [14:0][63:0] regs;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: register array, stop flag, status, retire count.
  logic [14:0][63:0] m_regs;
  logic              m_stop;
  logic [2:0]        m_stat;
  logic [31:0]       m_retired;
  exp_t              sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_regs    = '0;
    m_stop    = 1'b0;
    m_stat    = 3'd1;
    m_retired = '0;
  endtask

  function automatic logic [2:0] ref_status(input logic im, input logic ie, input logic de,
                                            input logic [3:0] ic);
    if (im) return 3'd3;
    if (ie) return 3'd4;
    if (de) return 3'd3;
    if (ic == 4'h0) return 3'd2;
    return 3'd1;
  endfunction

  task automatic model_accept(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                              input logic [3:0] b, input logic c, input logic [63:0] e,
                              input logic [63:0] m, input logic im, input logic ie, input logic de);
    logic [3:0] e_dst, m_dst;
    exp_t       x;
    m_stat    = ref_status(im, ie, de, ic);
    m_retired = m_retired + 32'd1;
    if (m_stat != 3'd1) m_stop = 1'b1;
    if (m_stat == 3'd1) begin
      e_dst = 4'hF;
      m_dst = 4'hF;
      if (ic == 4'h2 && (fn == 4'h0 || c)) e_dst = b;           // rrmovq / taken cmovXX
      if (ic == 4'h3 || ic == 4'h6)        e_dst = b;           // irmovq, OPq
      if (ic >= 4'h8 && ic <= 4'hB)        e_dst = 4'h4;        // stack ops adjust %rsp
      if (ic == 4'h5 || ic == 4'hB)        m_dst = a;           // mrmovq, popq
      if (e_dst != 4'hF) m_regs[e_dst] = e;
      if (m_dst != 4'hF) m_regs[m_dst] = m;                     // memory value overrides
    end
    x.stat    = m_stat;
    x.halted  = m_stop;
    x.retired = m_retired;
    x.regs    = m_regs;
    sb.push_back(x);
  endtask

  // Present one instruction for one cycle; returns at posedge+1.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                       input logic [3:0] b, input logic c, input logic [63:0] e,
                       input logic [63:0] m, input logic im, input logic ie, input logic de);
    wb_valid = 1'b1;
    icode = ic; ifun = fn; ra = a; rb = b; cnd = c;
    valE = e; valM = m;
    imem_error = im; instr_err = ie; dmem_error = de;
    srcA = 4'($urandom_range(0, 15));
    srcB = 4'($urandom_range(0, 15));
    if (!m_stop) model_accept(ic, fn, a, b, c, e, m, im, ie, de);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input logic [3:0] r);
    srcA = r;
    #1;
    check("reg_read", valA, (r == 4'hF) ? 64'd0 : m_regs[r]);
    check("stat", 64'(stat), 64'(m_stat));
    check("halted", 64'(halted), 64'(m_stop));
    check("retired", 64'(retired), 64'(m_retired));
  endtask

  // Drain the scoreboard, then pulse reset in mid-cycle and check the clear.
  task automatic do_reset(input logic [3:0] r);
    wb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    srcA  = r;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_reg", valA, 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_wb_done", 64'(wb_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every wb_done pulse must match the oldest expected retirement.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && wb_done) begin
        if (sb.size() == 0) begin
          check("spurious_wb_done", 64'(wb_done), 64'd0);
        end else begin
          x = sb.pop_front();
          check("sb_stat", 64'(stat), 64'(x.stat));
          check("sb_halted", 64'(halted), 64'(x.halted));
          check("sb_retired", 64'(retired), 64'(x.retired));
          check("sb_valA", valA, (srcA == 4'hF) ? 64'd0 : x.regs[srcA]);
          check("sb_valB", valB, (srcB == 4'hF) ? 64'd0 : x.regs[srcB]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0;
    icode = '0; ifun = '0; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0;
    imem_error = 1'b0; instr_err = 1'b0; dmem_error = 1'b0;
    srcA = 4'h0; srcB = 4'h3;
    model_reset();
    #12;
    check("init_stat", 64'(stat), 64'd1);
    check("init_halted", 64'(halted), 64'd0);
    check("init_retired", 64'(retired), 64'd0);
    check("init_wb_done", 64'(wb_done), 64'd0);
    check("init_valB", valB, 64'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // irmovq into r2, visible next cycle.
    issue(4'h3, 4'h0, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0);
    srcB = 4'h2;
    #1;
    check("irmovq_valB", valB, 64'h1234);
    check_state(4'h2);

    // Conditional move: not taken, then taken.
    issue(4'h2, 4'h5, 4'h1, 4'h3, 1'b0, 64'h7, 64'h0, 1'b0, 1'b0, 1'b0);
    check_state(4'h3);
    issue(4'h2, 4'h5, 4'h1, 4'h3, 1'b1, 64'h7, 64'h0, 1'b0, 1'b0, 1'b0);
    check_state(4'h3);

    // popq %rsp: memory value beats the stack-pointer update.
    issue(4'hB, 4'h0, 4'h4, 4'hF, 1'b0, 64'h100, 64'h55, 1'b0, 1'b0, 1'b0);
    check_state(4'h4);

    // r5 = 9, halt, then an ignored irmovq.
    issue(4'h3, 4'h0, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_state(4'h5);
    issue(4'h3, 4'h0, 4'hF, 4'h1, 1'b0, 64'hDEAD, 64'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check_state(4'h1);
    do_reset(4'h5);

    // Invalid instruction on OPq: INS, no write.
    issue(4'h6, 4'h0, 4'h1, 4'h2, 1'b0, 64'h77, 64'h0, 1'b0, 1'b1, 1'b0);
    check_state(4'h2);
    do_reset(4'h2);

    // imem fault outranks instr fault.
    issue(4'h3, 4'h0, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b1, 1'b1, 1'b0);
    check_state(4'h6);
    do_reset(4'h6);

    // Data fault on mrmovq: ADR, no write.
    issue(4'h5, 4'h0, 4'h7, 4'hF, 1'b0, 64'h0, 64'h99, 1'b0, 1'b0, 1'b1);
    check_state(4'h7);
    do_reset(4'h7);

    // Randomized back-to-back streams.
    for (int n = 0; n < 400; n++) begin
      if (m_stop) begin
        check_state(4'($urandom_range(0, 15)));
        do_reset(4'($urandom_range(0, 14)));
      end else if ($urandom_range(0, 7) == 0) begin
        idle();
      end else begin
        issue(($urandom_range(0, 39) == 0) ? 4'h0 : 4'($urandom_range(1, 11)),
              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 6)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 59) == 0), ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 59) == 0));
      end
    end

    idle();
    idle();
    check_state(4'($urandom_range(0, 15)));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
